// File: rtl/paddle_ctrl_if.sv
// Paddle controller signal bundle: requests and scan position in, paddle state out.
// The master drives the requests and scan coordinates; the slave (the controller) drives the paddle state.
interface paddle_ctrl_if #(
  parameter int RW = 9,
  parameter int CW = 10,
  parameter int SW = 3
);
  logic          up;
  logic          down;
  logic          auto_en;
  logic [RW-1:0] ball_y;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [RW-1:0] pos;
  logic          paddle_present;
  logic [1:0]    dir;
  logic [SW-1:0] speed;

  modport master (
    output up, down, auto_en, ball_y, row, col,
    input  pos, paddle_present, dir, speed
  );

  modport slave (
    input  up, down, auto_en, ball_y, row, col,
    output pos, paddle_present, dir, speed
  );
endinterface

// File: rtl/paddle_ctrl.sv
// Paddle position controller with manual/auto-track modes and stepped acceleration.
// pos/dir/speed update on the movement tick and are visible one cycle later; paddle_present is combinational.
module paddle_ctrl #(
  parameter int CLKS_PER_MOVE  = 250_000,
  parameter int ACTIVE_ROWS    = 480,
  parameter int ACTIVE_COLS    = 640,
  parameter int WIDTH          = 16,
  parameter int HEIGHT         = 64,
  parameter int IS_LEFT_PADDLE = 1,
  parameter int MARGIN         = 4,
  parameter int MAX_STEP       = 4,
  parameter int ACCEL_MOVES    = 8,
  parameter int DEADBAND       = 8
) (
  input logic           clk,
  input logic           rst,
  paddle_ctrl_if.slave  bus
);
  localparam int RW   = $clog2(ACTIVE_ROWS);
  localparam int CW   = $clog2(ACTIVE_COLS);
  localparam int SW   = $clog2(MAX_STEP + 1);
  localparam int TW   = $clog2(CLKS_PER_MOVE);
  localparam int NW   = $clog2(ACCEL_MOVES) + 1;
  localparam int XPOS = (IS_LEFT_PADDLE != 0) ? WIDTH / 2 : ACTIVE_COLS - 1 - WIDTH * 3 / 2;

  localparam logic [RW:0]   TOP_LIM = (RW+1)'(MARGIN);
  localparam logic [RW:0]   BOT_LIM = (RW+1)'(ACTIVE_ROWS - HEIGHT - MARGIN);
  localparam logic [RW-1:0] Y_INIT  = RW'(ACTIVE_ROWS / 2 - HEIGHT / 2);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } state_t;

  state_t        state_q, state_d, req;
  logic [TW-1:0] cnt_q;
  logic [RW-1:0] y_q, y_d;
  logic [SW-1:0] step_q, step_d, move;
  logic [NW-1:0] run_q, run_d;
  logic          tick, go;
  logic [RW:0]   centre, ball_w, move_w, y_w;

  assign tick   = (cnt_q == TW'(CLKS_PER_MOVE - 1));
  assign y_w    = {1'b0, y_q};
  assign centre = y_w + (RW+1)'(HEIGHT / 2);
  assign ball_w = {1'b0, bus.ball_y};
  assign move_w = (RW+1)'(move);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= IDLE;
      y_q     <= Y_INIT;
      step_q  <= SW'(1);
      run_q   <= '0;
    end else begin
      cnt_q   <= tick ? '0 : cnt_q + TW'(1);
      state_q <= state_d;
      y_q     <= y_d;
      step_q  <= step_d;
      run_q   <= run_d;
    end
  end

  // Auto mode works in RW+1 bits so neither side of the deadband compare can wrap.
  always_comb begin
    req = IDLE;
    if (bus.auto_en) begin
      if (ball_w + (RW+1)'(DEADBAND) < centre) req = UP;
      else if (ball_w > centre + (RW+1)'(DEADBAND)) req = DOWN;
    end else if (bus.up && !bus.down) begin
      req = UP;
    end else if (bus.down && !bus.up) begin
      req = DOWN;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    step_d  = step_q;
    run_d   = run_q;
    move    = '0;
    go      = 1'b0;
    if (tick) begin
      if (req == IDLE) begin
        state_d = IDLE;
        step_d  = SW'(1);
        run_d   = '0;
      end else if (req != state_q) begin
        state_d = req;
        step_d  = SW'(1);
        run_d   = '0;
        move    = SW'(1);
        go      = 1'b1;
      end else begin
        move = step_q;
        go   = 1'b1;
        if (int'(run_q) + 1 >= ACCEL_MOVES - 1) begin
          if (int'(step_q) < MAX_STEP) begin
            step_d = step_q + SW'(1);
            run_d  = '0;
          end else begin
            run_d = NW'(ACCEL_MOVES - 1);
          end
        end else begin
          run_d = run_q + NW'(1);
        end
      end
      // Hitting an edge drops back to the slowest step but keeps the direction.
      if (go) begin
        if (state_d == UP) begin
          if (y_w < TOP_LIM + move_w) begin
            y_d    = TOP_LIM[RW-1:0];
            step_d = SW'(1);
            run_d  = '0;
          end else begin
            y_d = y_q - RW'(move);
          end
        end else begin
          if (y_w + move_w > BOT_LIM) begin
            y_d    = BOT_LIM[RW-1:0];
            step_d = SW'(1);
            run_d  = '0;
          end else begin
            y_d = y_q + RW'(move);
          end
        end
      end
    end
  end

  assign bus.pos   = y_q;
  assign bus.dir   = state_q;
  assign bus.speed = step_q;

  assign bus.paddle_present = ({1'b0, bus.row} >= y_w) &&
                              ({1'b0, bus.row} <  y_w + (RW+1)'(HEIGHT)) &&
                              ({1'b0, bus.col} >= (CW+1)'(XPOS)) &&
                              ({1'b0, bus.col} <  (CW+1)'(XPOS + WIDTH));
endmodule

// File: tb/tb_paddle_ctrl.sv
// Randomised scoreboard bench for paddle_ctrl with a tick-level reference model.
module tb_paddle_ctrl;
  localparam int CPM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  paddle_ctrl_if #(.RW(9), .CW(10), .SW(3)) bus();

  paddle_ctrl #(.CLKS_PER_MOVE(CPM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [13:0] exp_q[$];
  logic [13:0] held;

  int m_pos  = 208;
  int m_dir  = 0;
  int m_step = 1;
  int m_run  = 0;

  int cur_row = 0;
  int cur_col = 0;
  int dir_pt  = -1;
  int pr[3] = '{208, 272, 208};
  int pc[3] = '{8, 8, 24};

  int mcnt = 0;
  int ev   = 0;   // 0 plain cycle, 1 reset edge, 2 tick edge

  function automatic logic [13:0] pack(int p, int d, int s);
    return {p[8:0], d[1:0], s[2:0]};
  endfunction

  // Reference: one movement tick, straight from the behavioural rules.
  function automatic void model_tick(bit u, bit d, bit a, int ball);
    int req;
    int mv;
    int centre;
    req = 0;
    if (a) begin
      centre = m_pos + 32;
      if (ball + 8 < centre) req = 1;
      else if (ball > centre + 8) req = 2;
    end else if (u && !d) req = 1;
    else if (d && !u) req = 2;
    if (req == 0) begin
      m_dir = 0; m_step = 1; m_run = 0;
      return;
    end
    if (req != m_dir) begin
      m_dir = req; m_step = 1; m_run = 0; mv = 1;
    end else begin
      mv = m_step;
      m_run = m_run + 1;
      if (m_run >= 7) begin
        if (m_step < 4) begin m_step = m_step + 1; m_run = 0; end
        else m_run = 7;
      end
    end
    if (req == 1) begin
      if (m_pos - mv < 4) begin m_pos = 4; m_step = 1; m_run = 0; end
      else m_pos = m_pos - mv;
    end else begin
      if (m_pos + mv > 412) begin m_pos = 412; m_step = 1; m_run = 0; end
      else m_pos = m_pos + mv;
    end
  endfunction

  task automatic check_state(string name, logic [13:0] got, logic [13:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t: got pos=%0d dir=%0d speed=%0d, want pos=%0d dir=%0d speed=%0d",
               name, $time, got[13:5], got[4:3], got[2:0], want[13:5], want[4:3], want[2:0]);
    end
  endtask

  // Junk inputs on non-tick cycles must be ignored; the real request lands just before the tick edge.
  task automatic do_tick(bit u, bit d, bit a, int ball);
    for (int k = 0; k < CPM; k++) begin
      @(negedge clk);
      rst = 1'b0;
      if (k == CPM - 1) begin
        bus.up = u; bus.down = d; bus.auto_en = a; bus.ball_y = 9'(ball);
      end else begin
        bus.up      = 1'($urandom_range(0, 1));
        bus.down    = 1'($urandom_range(0, 1));
        bus.auto_en = 1'($urandom_range(0, 1));
        bus.ball_y  = 9'($urandom_range(0, 479));
      end
      @(posedge clk);
    end
    model_tick(u, d, a, ball);
    exp_q.push_back(pack(m_pos, m_dir, m_step));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    m_pos = 208; m_dir = 0; m_step = 1; m_run = 0;
  endtask

  // Scan coordinate driver: mostly near the paddle edges, sometimes anywhere.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (dir_pt >= 0 && dir_pt < 3) begin
        cur_row = pr[dir_pt];
        cur_col = pc[dir_pt];
        dir_pt++;
      end else begin
        cur_row = m_pos - 3 + int'($urandom_range(0, 70));
        if (cur_row < 0) cur_row = 0;
        if (cur_row > 479) cur_row = 479;
        if ($urandom_range(0, 3) == 0) cur_col = int'($urandom_range(0, 639));
        else cur_col = 5 + int'($urandom_range(0, 22));
      end
      bus.row = 9'(cur_row);
      bus.col = 10'(cur_col);
    end
  end

  // Independent tick timeline: first tick is the CPM-th edge after the last reset edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mcnt = 0; ev = 1;
      end else if (mcnt == CPM - 1) begin
        mcnt = 0; ev = 2;
      end else begin
        mcnt = mcnt + 1; ev = 0;
      end
    end
  end

  initial begin
    logic [13:0] got;
    logic        exp_pres;
    int          p;
    forever begin
      @(negedge clk);
      got = {bus.pos, bus.dir, bus.speed};
      if (ev == 1) begin
        held = pack(208, 0, 1);
        check_state("reset", got, held);
      end else if (ev == 2) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL tick_no_expect t=%0t: got pos=%0d, required a queued expectation", $time, got[13:5]);
        end else begin
          held = exp_q.pop_front();
          check_state("tick", got, held);
        end
      end else begin
        check_state("hold", got, held);
      end
      p = int'(held[13:5]);
      exp_pres = (cur_row >= p) && (cur_row < p + 64) && (cur_col >= 8) && (cur_col < 24);
      total++;
      if (bus.paddle_present !== exp_pres) begin
        bad++;
        $display("FAIL presence t=%0t row=%0d col=%0d pos=%0d: got %b want %b",
                 $time, cur_row, cur_col, p, bus.paddle_present, exp_pres);
      end
    end
  end

  initial begin
    bus.up = 1'b0; bus.down = 1'b0; bus.auto_en = 1'b0; bus.ball_y = '0;
    bus.row = '0; bus.col = '0;
    do_reset();
    do_reset();
    repeat (10) do_tick(0, 0, 0, 0);
    dir_pt = 0;
    repeat (17) do_tick(1, 0, 0, 0);
    repeat (70) do_tick(0, 1, 0, 0);
    repeat (2)  do_tick(0, 0, 0, 0);
    repeat (10) do_tick(1, 0, 0, 0);
    repeat (2)  do_tick(1, 1, 0, 0);
    repeat (3)  do_tick(0, 1, 0, 0);
    repeat (20) do_tick(0, 0, 1, 100);
    repeat (3)  do_tick(0, 0, 1, 250);
    repeat (18) do_tick(0, 1, 0, 0);
    repeat (2) @(posedge clk);
    do_reset();
    repeat (5) do_tick(1, 0, 0, 0);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 479)));
    end
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
